sram_like_arbiter: RTL and testbench

//  Sits directly downstream of the CPU core's two sram-like master ports (inst, data); merges them onto one sram-like port to the memory bridge.

---
 rtl/sram_like_arbiter_if.sv | 14 +
 rtl/sram_like_arbiter.sv | 130 +++++++++++++
 tb/tb_sram_like_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_like_arbiter_if.sv
// One sram-like port: the requester drives req/wr/size/addr/wdata, the responder returns rdata/addr_ok/data_ok.
interface sram_like_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
  modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/sram_like_arbiter.sv
// Merges the core's inst and data sram-like ports onto one memory port, returning completions in order.
// Define SRAM_ARB_RR_EN for round-robin arbitration; the default build is fixed data-over-inst priority.
module sram_like_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  sram_like_arbiter_if.slave   i_inst,
  sram_like_arbiter_if.slave   i_data,
  sram_like_arbiter_if.master  o_mem
);

  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(OUTSTANDING);
  localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING - 1);

  // state   | meaning
  // ST_FREE | no address phase pending, grant chosen by priority each cycle
  // ST_HOLD | mem_req stalled by mem_addr_ok=0, grant frozen on r_lock_id
  localparam logic [0:0] ST_FREE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]             r_state;
  logic                   r_lock_id;
  logic [OUTSTANDING-1:0] r_fifo;
  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;

  logic w_pref;
  logic w_sel;
  logic w_src_req;
  logic w_not_full;
  logic w_mem_req;
  logic w_accept;
  logic w_pop;
  logic w_head;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

`ifdef SRAM_ARB_RR_EN
  logic r_last;

  // Whichever port lost the last accept is preferred; reset value favours data.
  assign w_pref = ~r_last;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_last <= 1'b0;
    end else if (w_accept) begin
      r_last <= w_sel;
    end
  end
`else
  assign w_pref = 1'b1;
`endif

  always_comb begin
    w_sel = 1'b0;
    if (r_state == ST_HOLD) begin
      w_sel = r_lock_id;
    end else if (i_data.req && i_inst.req) begin
      w_sel = w_pref;
    end else begin
      w_sel = i_data.req;
    end
  end

  assign w_src_req  = w_sel ? i_data.req : i_inst.req;
  assign w_not_full = (r_count < CNT_MAX);
  assign w_mem_req  = resetn & w_src_req & w_not_full;
  assign w_accept   = w_mem_req & o_mem.addr_ok;
  assign w_head     = r_fifo[r_rd_ptr];
  assign w_pop      = resetn & o_mem.data_ok & (r_count != '0);

  assign o_mem.req   = w_mem_req;
  assign o_mem.wr    = w_sel ? i_data.wr    : i_inst.wr;
  assign o_mem.size  = w_sel ? i_data.size  : i_inst.size;
  assign o_mem.addr  = w_sel ? i_data.addr  : i_inst.addr;
  assign o_mem.wdata = w_sel ? i_data.wdata : i_inst.wdata;

  assign i_inst.addr_ok = w_accept & ~w_sel;
  assign i_data.addr_ok = w_accept &  w_sel;
  assign i_inst.data_ok = w_pop & ~w_head;
  assign i_data.data_ok = w_pop &  w_head;
  assign i_inst.rdata   = o_mem.rdata;
  assign i_data.rdata   = o_mem.rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= ST_FREE;
      r_lock_id <= 1'b0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      if (r_state == ST_FREE) begin
        if (w_mem_req && !o_mem.addr_ok) begin
          r_state   <= ST_HOLD;
          r_lock_id <= w_sel;
        end
      end else if (w_accept) begin
        r_state <= ST_FREE;
      end

      if (w_accept) begin
        r_wr_ptr <= f_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= f_next(r_rd_ptr);
      end
      if (w_accept && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_accept && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // ID storage needs no reset: entries are only read once counted.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_fifo[r_wr_ptr] <= w_sel;
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scenario bench for sram_like_arbiter: expected completion IDs are queued at acceptance and checked at mem_data_ok.
module tb_sram_like_arbiter;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  sram_like_arbiter_if inst_if ();
  sram_like_arbiter_if data_if ();
  sram_like_arbiter_if mem_if ();

  sram_like_arbiter #(.OUTSTANDING(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .i_inst (inst_if),
    .i_data (data_if),
    .o_mem  (mem_if)
  );

  int n_pass = 0;
  int n_total = 0;

  logic        q_id[$];
  logic [31:0] q_rd[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd2;
    inst_if.addr = 32'h0; inst_if.wdata = 32'h0;
    data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd2;
    data_if.addr = 32'h0; data_if.wdata = 32'h0;
    mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = 32'h0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    inst_if.req = 1'b1; data_if.req = 1'b1;
    mem_if.addr_ok = 1'b1; mem_if.data_ok = 1'b1;
    tick; tick; #3;
    n_total++;
    if (mem_if.req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_if.req);
    else n_pass++;
    n_total++;
    if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b00)
      $display("FAIL rst_addr_ok: got %b want 00", {inst_if.addr_ok, data_if.addr_ok});
    else n_pass++;
    n_total++;
    if ({inst_if.data_ok, data_if.data_ok} !== 2'b00)
      $display("FAIL rst_data_ok: got %b want 00", {inst_if.data_ok, data_if.data_ok});
    else n_pass++;
    tick;
    idle_inputs();
    resetn = 1'b1;
  endtask

  task automatic test_single_inst();
    logic e_id; logic [31:0] e_rd;
    tick;
    inst_if.req = 1'b1; inst_if.addr = 32'hBFC00000; mem_if.addr_ok = 1'b1;
    #3;
    n_total++;
    if (mem_if.req !== 1'b1 || mem_if.addr !== 32'hBFC00000)
      $display("FAIL single_mem: got req=%b addr=%h want req=1 addr=bfc00000", mem_if.req, mem_if.addr);
    else n_pass++;
    n_total++;
    if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b10)
      $display("FAIL single_addr_ok: got %b want 10", {inst_if.addr_ok, data_if.addr_ok});
    else n_pass++;
    q_id.push_back(1'b0); q_rd.push_back(32'h24010001);
    tick;
    inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
    #3;
    n_total++;
    if ({inst_if.data_ok, data_if.data_ok} !== 2'b00)
      $display("FAIL single_early_data_ok: got %b want 00", {inst_if.data_ok, data_if.data_ok});
    else n_pass++;
    tick;
    e_id = q_id.pop_front(); e_rd = q_rd.pop_front();
    mem_if.data_ok = 1'b1; mem_if.rdata = e_rd;
    #3;
    n_total++;
    if ({inst_if.data_ok, data_if.data_ok} !== {~e_id, e_id})
      $display("FAIL single_data_ok: got %b want %b", {inst_if.data_ok, data_if.data_ok}, {~e_id, e_id});
    else n_pass++;
    n_total++;
    if (inst_if.rdata !== e_rd) $display("FAIL single_rdata: got %h want %h", inst_if.rdata, e_rd);
    else n_pass++;
    tick;
    mem_if.data_ok = 1'b0;
  endtask

  task automatic test_both_same_cycle();
    logic e_id; logic [31:0] e_rd;
    tick;
    inst_if.req = 1'b1; inst_if.addr = 32'h00001000;
    data_if.req = 1'b1; data_if.addr = 32'h00002000; data_if.wr = 1'b1; data_if.wdata = 32'hCAFEF00D;
    mem_if.addr_ok = 1'b1;
    #3;
    n_total++;
    if (mem_if.addr !== 32'h00002000 || mem_if.wr !== 1'b1 || mem_if.wdata !== 32'hCAFEF00D)
      $display("FAIL both_first: got addr=%h wr=%b wdata=%h want 00002000 1 cafef00d",
               mem_if.addr, mem_if.wr, mem_if.wdata);
    else n_pass++;
    n_total++;
    if ({inst_if.addr_ok, data_if.addr_ok} !== 2'b01)
      $display("FAIL both_first_addr_ok: got %b want 01", {inst_if.addr_ok, data_if.addr_ok});
    else n_pass++;
    q_id.push_back(1'b1); q_rd.push_back(32'hAAAA0001);
    tick;
    data_if.req = 1'b0; data_if.wr = 1'b0;
    #3;
    n_total++;
    if (mem_if.addr !== 32'h00001000 || {inst_if.addr_ok, data_if.addr_ok} !== 2'b10)
      $display("FAIL both_second: got addr=%h ok=%b want 00001000 10",
               mem_if.addr, {inst_if.addr_ok, data_if.addr_ok});
    else n_pass++;
    q_id.push_back(1'b0); q_rd.push_back(32'hBBBB0002);
    for (int k = 0; k < 2; k++) begin
      tick;
      inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
      e_id = q_id.pop_front(); e_rd = q_rd.pop_front();
      mem_if.data_ok = 1'b1; mem_if.rdata = e_rd;
      #3;
      n_total++;
      if ({inst_if.data_ok, data_if.data_ok} !== {~e_id, e_id})
        $display("FAIL both_order: got %b want %b", {inst_if.data_ok, data_if.data_ok}, {~e_id, e_id});
      else n_pass++;
      n_total++;
      if ((e_id ? data_if.rdata : inst_if.rdata) !== e_rd)
        $display("FAIL both_rdata: got %h want %h", (e_id ? data_if.rdata : inst_if.rdata), e_rd);
      else n_pass++;
    end
    tick;
    mem_if.data_ok = 1'b0;
  endtask

  task automatic test_lock();
    logic e_id; logic [31:0] e_rd;
    // data stalled, inst joins: data must stay granted
    tick;
    data_if.req = 1'b1; data_if.addr = 32'h00003000;
    #3;
    for (int k = 1; k < 4; k++) begin
      tick;
      inst_if.req = 1'b1; inst_if.addr = 32'h00004000;
      if (k == 3) mem_if.addr_ok = 1'b1;
      #3;
      n_total++;
      if (mem_if.addr !== 32'h00003000 || inst_if.addr_ok !== 1'b0 || data_if.addr_ok !== (k == 3))
        $display("FAIL lock_data_hold: cycle %0d got addr=%h ok=%b want 00003000 %b",
                 k, mem_if.addr, {inst_if.addr_ok, data_if.addr_ok}, {1'b0, (k == 3)});
      else n_pass++;
    end
    q_id.push_back(1'b1); q_rd.push_back(32'h30003000);
    tick;
    data_if.req = 1'b0;
    #3;
    n_total++;
    if (mem_if.addr !== 32'h00004000 || {inst_if.addr_ok, data_if.addr_ok} !== 2'b10)
      $display("FAIL lock_data_then_inst: got addr=%h ok=%b want 00004000 10",
               mem_if.addr, {inst_if.addr_ok, data_if.addr_ok});
    else n_pass++;
    q_id.push_back(1'b0); q_rd.push_back(32'h40004000);
    for (int k = 0; k < 2; k++) begin
      tick;
      inst_if.req = 1'b0; data_if.req = 1'b0; mem_if.addr_ok = 1'b0;
      e_id = q_id.pop_front(); e_rd = q_rd.pop_front();
      mem_if.data_ok = 1'b1; mem_if.rdata = e_rd;
      #3;
      n_total++;
      if ({inst_if.data_ok, data_if.data_ok} !== {~e_id, e_id})
        $display("FAIL lock_a_order: got %b want %b", {inst_if.data_ok, data_if.data_ok}, {~e_id, e_id});
      else n_pass++;
    end
    // inst stalled, data joins: a dropped lock would let data jump in
    tick;
    mem_if.data_ok = 1'b0;
    inst_if.req = 1'b1; inst_if.addr = 32'h00005000;
    #3;
    for (int k = 1; k < 4; k++) begin
      tick;
      data_if.req = 1'b1; data_if.addr = 32'h00006000;
      if (k == 3) mem_if.addr_ok = 1'b1;
      #3;
      n_total++;
      if (mem_if.addr !== 32'h00005000 || data_if.addr_ok !== 1'b0 || inst_if.addr_ok !== (k == 3))
        $display("FAIL lock_inst_hold: cycle %0d got addr=%h ok=%b want 00005000 %b",
                 k, mem_if.addr, {inst_if.addr_ok, data_if.addr_ok}, {(k == 3), 1'b0});
      else n_pass++;
    end
    q_id.push_back(1'b0); q_rd.push_back(32'h50005000);
    tick;
    inst_if.req = 1'b0;
    #3;
    n_total++;
    if (mem_if.addr !== 32'h00006000 || {inst_if.addr_ok, data_if.addr_ok} !== 2'b01)
      $display("FAIL lock_inst_then_data: got addr=%h ok=%b want 00006000 01",
               mem_if.addr, {inst_if.addr_ok, data_if.addr_ok});
    else n_pass++;
    q_id.push_back(1'b1); q_rd.push_back(32'h60006000);
    for (int k = 0; k < 2; k++) begin
      tick;
      inst_if.req = 1'b0; data_if.req = 1'b0; mem_if.addr_ok = 1'b0;
      e_id = q_id.pop_front(); e_rd = q_rd.pop_front();
      mem_if.data_ok = 1'b1; mem_if.rdata = e_rd;
      #3;
      n_total++;
      if ({inst_if.data_ok, data_if.data_ok} !== {~e_id, e_id})
        $display("FAIL lock_b_order: got %b want %b", {inst_if.data_ok, data_if.data_ok}, {~e_id, e_id});
      else n_pass++;
      n_total++;
      if ((e_id ? data_if.rdata : inst_if.rdata) !== e_rd)
        $display("FAIL lock_b_rdata: got %h want %h", (e_id ? data_if.rdata : inst_if.rdata), e_rd);
      else n_pass++;
    end
    tick;
    mem_if.data_ok = 1'b0;
  endtask

  task automatic test_full();
    logic e_id; logic [31:0] e_rd;
    tick;
    data_if.req = 1'b1; data_if.addr = 32'h00007000; mem_if.addr_ok = 1'b1;
    #3;
    q_id.push_back(1'b1); q_rd.push_back(32'h11111111);
    tick;
    #3;
    n_total++;
    if (data_if.addr_ok !== 1'b1) $display("FAIL full_second_accept: got %b want 1", data_if.addr_ok);
    else n_pass++;
    q_id.push_back(1'b1); q_rd.push_back(32'h22222222);
    tick;
    #3;
    n_total++;
    if (mem_if.req !== 1'b0 || data_if.addr_ok !== 1'b0)
      $display("FAIL full_block: got req=%b addr_ok=%b want 0 0", mem_if.req, data_if.addr_ok);
    else n_pass++;
    tick;
    e_id = q_id.pop_front(); e_rd = q_rd.pop_front();
    mem_if.data_ok = 1'b1; mem_if.rdata = e_rd;
    #3;
    n_total++;
    if (mem_if.req !== 1'b0 || data_if.addr_ok !== 1'b0)
      $display("FAIL full_block_with_pop: got req=%b addr_ok=%b want 0 0", mem_if.req, data_if.addr_ok);
    else n_pass++;
    n_total++;
    if ({inst_if.data_ok, data_if.data_ok} !== {~e_id, e_id})
      $display("FAIL full_pop: got %b want %b", {inst_if.data_ok, data_if.data_ok}, {~e_id, e_id});
    else n_pass++;
    tick;
    mem_if.data_ok = 1'b0;
    #3;
    n_total++;
    if (mem_if.req !== 1'b1 || data_if.addr_ok !== 1'b1)
      $display("FAIL full_reopen: got req=%b addr_ok=%b want 1 1", mem_if.req, data_if.addr_ok);
    else n_pass++;
    q_id.push_back(1'b1); q_rd.push_back(32'h33333333);
    for (int k = 0; k < 2; k++) begin
      tick;
      data_if.req = 1'b0; mem_if.addr_ok = 1'b0;
      e_id = q_id.pop_front(); e_rd = q_rd.pop_front();
      mem_if.data_ok = 1'b1; mem_if.rdata = e_rd;
      #3;
      n_total++;
      if (data_if.data_ok !== 1'b1 || data_if.rdata !== e_rd)
        $display("FAIL full_drain: got ok=%b rdata=%h want 1 %h", data_if.data_ok, data_if.rdata, e_rd);
      else n_pass++;
    end
    tick;
    mem_if.data_ok = 1'b0;
  endtask

  task automatic test_reset_midflight();
    logic e_id; logic [31:0] e_rd;
    tick;
    inst_if.req = 1'b1; inst_if.addr = 32'h00008000; mem_if.addr_ok = 1'b1;
    tick;
    inst_if.req = 1'b0; data_if.req = 1'b1; data_if.addr = 32'h00009000;
    tick;
    data_if.req = 1'b0; mem_if.addr_ok = 1'b0; resetn = 1'b0;
    #3;
    n_total++;
    if (mem_if.req !== 1'b0) $display("FAIL midrst_mem_req: got %b want 0", mem_if.req);
    else n_pass++;
    tick;
    resetn = 1'b1;
    q_id.delete(); q_rd.delete();
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'hDEAD0000;
    data_if.req = 1'b1; data_if.addr = 32'h0000A000; mem_if.addr_ok = 1'b1;
    #3;
    n_total++;
    if ({inst_if.data_ok, data_if.data_ok} !== 2'b00)
      $display("FAIL midrst_stray_data_ok: got %b want 00", {inst_if.data_ok, data_if.data_ok});
    else n_pass++;
    n_total++;
    if (mem_if.req !== 1'b1 || data_if.addr_ok !== 1'b1)
      $display("FAIL midrst_count_first: got req=%b ok=%b want 1 1", mem_if.req, data_if.addr_ok);
    else n_pass++;
    q_id.push_back(1'b1); q_rd.push_back(32'hA000A000);
    tick;
    mem_if.data_ok = 1'b0;
    data_if.req = 1'b0; inst_if.req = 1'b1; inst_if.addr = 32'h0000B000;
    #3;
    n_total++;
    if (mem_if.req !== 1'b1 || inst_if.addr_ok !== 1'b1)
      $display("FAIL midrst_count_second: got req=%b ok=%b want 1 1", mem_if.req, inst_if.addr_ok);
    else n_pass++;
    q_id.push_back(1'b0); q_rd.push_back(32'hB000B000);
    for (int k = 0; k < 2; k++) begin
      tick;
      inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
      e_id = q_id.pop_front(); e_rd = q_rd.pop_front();
      mem_if.data_ok = 1'b1; mem_if.rdata = e_rd;
      #3;
      n_total++;
      if ({inst_if.data_ok, data_if.data_ok} !== {~e_id, e_id})
        $display("FAIL midrst_drain: got %b want %b", {inst_if.data_ok, data_if.data_ok}, {~e_id, e_id});
      else n_pass++;
    end
    tick;
    mem_if.data_ok = 1'b0;
  endtask

  task automatic test_arbitration_order();
    logic e_id; logic [31:0] e_rd; logic x_sel;
    tick;
    resetn = 1'b0;
    tick;
    resetn = 1'b1;
    q_id.delete(); q_rd.delete();
    for (int k = 0; k < 4; k++) begin
      tick;
      inst_if.req = 1'b1; inst_if.addr = 32'h0000C000;
      data_if.req = 1'b1; data_if.addr = 32'h0000D000;
      mem_if.addr_ok = 1'b1;
`ifdef SRAM_ARB_RR_EN
      x_sel = (k % 2 == 0);
`else
      x_sel = 1'b1;
`endif
      if (k > 0) begin
        e_id = q_id.pop_front(); e_rd = q_rd.pop_front();
        mem_if.data_ok = 1'b1; mem_if.rdata = e_rd;
      end
      #3;
      n_total++;
      if ({inst_if.addr_ok, data_if.addr_ok} !== {~x_sel, x_sel} ||
          mem_if.addr !== (x_sel ? 32'h0000D000 : 32'h0000C000))
        $display("FAIL arb_grant: cycle %0d got ok=%b addr=%h want ok=%b", k,
                 {inst_if.addr_ok, data_if.addr_ok}, mem_if.addr, {~x_sel, x_sel});
      else n_pass++;
      if (k > 0) begin
        n_total++;
        if ({inst_if.data_ok, data_if.data_ok} !== {~e_id, e_id})
          $display("FAIL arb_complete: cycle %0d got %b want %b", k,
                   {inst_if.data_ok, data_if.data_ok}, {~e_id, e_id});
        else n_pass++;
      end
      q_id.push_back(x_sel); q_rd.push_back(32'hE0000000 + k);
    end
    tick;
    inst_if.req = 1'b0; data_if.req = 1'b0; mem_if.addr_ok = 1'b0;
    e_id = q_id.pop_front(); e_rd = q_rd.pop_front();
    mem_if.data_ok = 1'b1; mem_if.rdata = e_rd;
    #3;
    n_total++;
    if ({inst_if.data_ok, data_if.data_ok} !== {~e_id, e_id} ||
        (e_id ? data_if.rdata : inst_if.rdata) !== e_rd)
      $display("FAIL arb_last: got ok=%b want %b rdata want %h", {inst_if.data_ok, data_if.data_ok},
               {~e_id, e_id}, e_rd);
    else n_pass++;
    tick;
    mem_if.data_ok = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    idle_inputs();
    test_reset();
    test_single_inst();
    test_both_same_cycle();
    test_lock();
    test_full();
    test_reset_midflight();
    test_arbitration_order();
    tick;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
